uart_term_mon: RTL and testbench
================================

UART_TERM_MON -- requirements
Module: uart_term_mon

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, HCLK cycles per UART bit; legal range 4..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per character; legal range 5..9.
REQ-003 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits checked: 1 or 2.
REQ-005 SHALL have parameter FIFO_DEPTH, default 16, receive buffer entries; power of 2, minimum 2.
REQ-006 SHALL have port HCLK, input, 1, the single clock; all state on its rising edge.
REQ-007 SHALL have port HRESETn, input, 1, reset: asynchronous, active-low.
REQ-008 SHALL have port rx, input, 1, serial line (idle high), asynchronous to HCLK.
REQ-009 SHALL have port rd_en, input, 1, pops the FIFO head when rd_valid=1; ignored when empty.
REQ-010 SHALL have port rd_data, output, DATA_BITS, FIFO head (first-word fall-through), LSB = first bit received.
REQ-011 SHALL have port rd_valid, output, 1, FIFO not empty.
REQ-012 SHALL have port level, output, clog2(FIFO_DEPTH)+1, current FIFO occupancy.
REQ-013 SHALL have port frame_err, output, 1, one-cycle pulse on a bad stop bit.
REQ-014 SHALL have port parity_err, output, 1, one-cycle pulse on a parity mismatch.
REQ-015 SHALL have port overflow, output, 1, sticky: a character was dropped because the FIFO was full.
REQ-016 SHALL have port clr_err, input, 1, synchronous clear of overflow.
REQ-017 SHALL have port char_cnt, output, 16, count of characters accepted into the FIFO; wraps 0xFFFF->0.

Function
REQ-018 SHALL pass rx through a 2-flop synchroniser; all FSM decisions use the synchronised value rxs.
REQ-019 SHALL implement FSM states IDLE, START, DATA, PAR, STOP, BREAK with a bit-timer counter and a bit-index counter.
REQ-020 IDLE: a 1->0 transition on rxs SHALL enter START and load the timer for CLKS_PER_BIT/2.
REQ-021 START: at timer expiry, rxs=1 SHALL be treated as a false start -> IDLE with no pulse or push; rxs=0 -> DATA with the timer at CLKS_PER_BIT.
REQ-022 DATA: SHALL sample rxs at each timer expiry (mid-bit) into a shift register LSB-first; after DATA_BITS samples -> PAR if PARITY!=0, otherwise -> STOP.
REQ-023 PAR: SHALL sample one bit; odd mode requires odd total ones over data+parity, even mode requires even.
REQ-024 STOP: SHALL sample STOP_BITS bits; all sampled 1 -> character complete, go to IDLE in the same cycle as the last sample.
REQ-025 A character is good iff all stop bits are 1 and parity passes; a good character SHALL be pushed the cycle after the last stop sample and char_cnt SHALL increment in that same cycle.
REQ-026 Any stop bit sampled 0 SHALL pulse frame_err, SHALL NOT push, and SHALL enter BREAK; BREAK waits for rxs=1, then -> IDLE.
REQ-027 A parity failure with good stop bits SHALL pulse parity_err and SHALL NOT push; if both errors occur in one character, both pulses SHALL assert in the same cycle.
REQ-028 Push while full without a same-cycle pop SHALL drop the character, set overflow, and leave char_cnt unchanged.
REQ-029 Push and pop in the same cycle SHALL both take effect at any level, including full; level is unchanged.
REQ-030 rd_valid and rd_data SHALL update one cycle after a push to an empty FIFO.
REQ-031 clr_err SHALL clear overflow the next cycle; a simultaneous new overflow event SHALL take priority (overflow stays 1).
REQ-032 A start edge is recognised only in IDLE; rx activity in any other state SHALL NOT restart reception.

Reset
REQ-033 HRESETn low SHALL asynchronously force: FSM to IDLE, FIFO empty, rd_valid=0, rd_data=0, level=0, frame_err=0, parity_err=0, overflow=0, char_cnt=0, synchroniser flops=1.
REQ-034 Reset asserted mid-character SHALL discard the partial character; after release, the next valid start bit SHALL be received correctly.

Verification
REQ-035 Default parameters, send 0x41 at 16 clks/bit -> rd_valid=1 and rd_data=0x41 within 10*16+4 cycles of the start edge; char_cnt=1.
REQ-036 PARITY=2, send 0x55 with parity bit 1 -> parity_err pulses once; level stays 0; then 0x55 with parity 0 -> rd_data=0x55.
REQ-037 Hold rx low for 20 bit times, then release -> exactly one frame_err pulse; no push; the following 0x0D is received correctly.
REQ-038 A 0.3-bit-time low glitch on idle rx -> no pulse, no push, FSM back in IDLE.
REQ-039 FIFO_DEPTH=4, send 5 characters without reads -> level=4, overflow=1, char_cnt=4, FIFO holds the first 4; clr_err -> overflow=0; at full, simultaneous push and pop -> level stays 4 and order is preserved.
REQ-040 DATA_BITS=7, STOP_BITS=2, second stop bit 0 -> frame_err; HRESETn pulsed mid-DATA -> all outputs 0, and the next character is received intact.

Source files
------------

// File: rtl/uart_term_mon.sv
// uart_term_mon: UART receive monitor with start validation, parity and
// stop checking, break handling and a first-word fall-through FIFO.
module uart_term_mon #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        HCLK,
    input  logic                        HRESETn,
    input  logic                        rx,
    input  logic                        rd_en,
    output logic [DATA_BITS-1:0]        rd_data,
    output logic                        rd_valid,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        frame_err,
    output logic                        parity_err,
    output logic                        overflow,
    input  logic                        clr_err,
    output logic [15:0]                 char_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [15:0] HALF_LOAD = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_LOAD = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]  LAST_STOP = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        BREAK
    } state_t;

    logic [1:0] sync;
    logic       rxs;
    logic       rxs_d;

    state_t               state;
    state_t               state_nx;
    logic [15:0]          timer;
    logic [15:0]          timer_nx;
    logic [3:0]           bit_idx;
    logic [3:0]           bit_idx_nx;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_nx;
    logic                 par_bit;
    logic                 par_bit_nx;
    logic                 push;
    logic                 push_nx;
    logic                 ferr_nx;
    logic                 perr_nx;
    logic                 tick;
    logic                 par_ok;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;
    logic                 full;
    logic                 pop;
    logic                 wr;
    logic                 drop;

    // Synchroniser idles high so reset never fakes a start edge.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sync  <= 2'b11;
            rxs_d <= 1'b1;
        end else begin
            sync  <= {sync[0], rx};
            rxs_d <= rxs;
        end
    end

    assign rxs  = sync[1];
    assign tick = (timer == 16'd0);

    always_comb begin
        par_ok = 1'b1;
        if (PARITY == 1) begin
            par_ok = ^{shreg, par_bit};
        end else if (PARITY == 2) begin
            par_ok = ~^{shreg, par_bit};
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state      <= IDLE;
            timer      <= HALF_LOAD;
            bit_idx    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            push       <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            state      <= state_nx;
            timer      <= timer_nx;
            bit_idx    <= bit_idx_nx;
            shreg      <= shreg_nx;
            par_bit    <= par_bit_nx;
            push       <= push_nx;
            frame_err  <= ferr_nx;
            parity_err <= perr_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        timer_nx   = tick ? FULL_LOAD : timer - 16'd1;
        bit_idx_nx = bit_idx;
        shreg_nx   = shreg;
        par_bit_nx = par_bit;
        push_nx    = 1'b0;
        ferr_nx    = 1'b0;
        perr_nx    = 1'b0;
        unique case (state)
            IDLE: begin
                timer_nx   = HALF_LOAD;
                bit_idx_nx = '0;
                if (rxs_d && !rxs) begin
                    state_nx = START;
                end
            end
            START: begin
                if (tick) begin
                    state_nx = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shreg_nx = {rxs, shreg[DATA_BITS-1:1]};
                    if (bit_idx == LAST_DATA) begin
                        bit_idx_nx = '0;
                        state_nx   = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        bit_idx_nx = bit_idx + 4'd1;
                    end
                end
            end
            PAR: begin
                if (tick) begin
                    par_bit_nx = rxs;
                    state_nx   = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    if (!rxs) begin
                        ferr_nx  = 1'b1;
                        perr_nx  = !par_ok;
                        state_nx = BREAK;
                    end else if (bit_idx == LAST_STOP) begin
                        push_nx  = par_ok;
                        perr_nx  = !par_ok;
                        state_nx = IDLE;
                    end else begin
                        bit_idx_nx = bit_idx + 4'd1;
                    end
                end
            end
            BREAK: begin
                if (rxs) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // A push at full is still accepted when the head leaves that cycle.
    assign full     = count[AW];
    assign rd_valid = |count;
    assign pop      = rd_en && rd_valid;
    assign wr       = push && (!full || pop);
    assign drop     = push && full && !pop;
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;
    assign level    = count;

    always_ff @(posedge HCLK) begin
        if (wr) begin
            mem[wr_ptr] <= shreg;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            char_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr) begin
                wr_ptr   <= wr_ptr + AW'(1);
                char_cnt <= char_cnt + 16'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !wr) begin
                count <= count - (AW+1)'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_term_mon.sv
// tb_uart_term_mon: three parameterisations of the monitor driven with
// directed and random frames, checked against queue-based models.
`timescale 1ns/1ps
module tb_uart_term_mon;

    localparam int CPB = 16;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    logic       rx0 = 1'b1, rd_en0 = 1'b0, clr0 = 1'b0;
    logic [7:0] rd_data0;
    logic       rd_valid0, fe0, pe0, ov0;
    logic [4:0] level0;
    logic [15:0] cc0;

    logic       rx1 = 1'b1, rd_en1 = 1'b0, clr1 = 1'b0;
    logic [7:0] rd_data1;
    logic       rd_valid1, fe1, pe1, ov1;
    logic [2:0] level1;
    logic [15:0] cc1;

    logic       rx2 = 1'b1, rd_en2 = 1'b0, clr2 = 1'b0;
    logic [6:0] rd_data2;
    logic       rd_valid2, fe2, pe2, ov2;
    logic [4:0] level2;
    logic [15:0] cc2;

    uart_term_mon u0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .rx(rx0), .rd_en(rd_en0),
        .rd_data(rd_data0), .rd_valid(rd_valid0), .level(level0),
        .frame_err(fe0), .parity_err(pe0), .overflow(ov0),
        .clr_err(clr0), .char_cnt(cc0)
    );

    uart_term_mon #(.PARITY(2), .FIFO_DEPTH(4)) u1 (
        .HCLK(HCLK), .HRESETn(HRESETn), .rx(rx1), .rd_en(rd_en1),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .level(level1),
        .frame_err(fe1), .parity_err(pe1), .overflow(ov1),
        .clr_err(clr1), .char_cnt(cc1)
    );

    uart_term_mon #(.DATA_BITS(7), .STOP_BITS(2)) u2 (
        .HCLK(HCLK), .HRESETn(HRESETn), .rx(rx2), .rd_en(rd_en2),
        .rd_data(rd_data2), .rd_valid(rd_valid2), .level(level2),
        .frame_err(fe2), .parity_err(pe2), .overflow(ov2),
        .clr_err(clr2), .char_cnt(cc2)
    );

    int checks = 0;
    int errors = 0;
    int pcyc = 0;
    int t_start = 0;
    int fe_n [3];
    int pe_n [3];
    int cc1_chg = -1;
    logic [15:0] cc1_prev = '0;

    always @(posedge HCLK) begin
        pcyc <= pcyc + 1;
        if (fe0) fe_n[0] <= fe_n[0] + 1;
        if (fe1) fe_n[1] <= fe_n[1] + 1;
        if (fe2) fe_n[2] <= fe_n[2] + 1;
        if (pe0) pe_n[0] <= pe_n[0] + 1;
        if (pe1) pe_n[1] <= pe_n[1] + 1;
        if (pe2) pe_n[2] <= pe_n[2] + 1;
    end

    // Records the bench cycle at which u1 accepted its latest character.
    always @(negedge HCLK) begin
        if (cc1 !== cc1_prev) cc1_chg = pcyc;
        cc1_prev = cc1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int idx, input logic v);
        case (idx)
            0: rx0 = v;
            1: rx1 = v;
            default: rx2 = v;
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge HCLK);
    endtask

    // Serialises one frame: start, data LSB first, optional parity, stops.
    task automatic send(input int idx, input logic [8:0] d, input int nd,
                        input int pm, input bit badp,
                        input logic [1:0] stopv, input int ns,
                        input int cut);
        logic bits [$];
        logic ones;
        ones = 1'b0;
        bits.push_back(1'b0);
        for (int i = 0; i < nd; i++) begin
            bits.push_back(d[i]);
            ones ^= d[i];
        end
        if (pm != 0) bits.push_back(((pm == 1) ? ~ones : ones) ^ badp);
        for (int i = 0; i < ns; i++) bits.push_back(stopv[i]);
        t_start = pcyc;
        for (int i = 0; i < bits.size() && i < cut; i++) begin
            drive(idx, bits[i]);
            repeat (CPB) @(negedge HCLK);
        end
        drive(idx, 1'b1);
    endtask

    task automatic send_ok(input int idx, input logic [8:0] d, input int nd,
                           input int pm, input int ns);
        send(idx, d, nd, pm, 1'b0, 2'b11, ns, 99);
    endtask

    task automatic pop(input int idx);
        case (idx)
            0: rd_en0 = 1'b1;
            1: rd_en1 = 1'b1;
            default: rd_en2 = 1'b1;
        endcase
        @(negedge HCLK);
        rd_en0 = 1'b0;
        rd_en1 = 1'b0;
        rd_en2 = 1'b0;
    endtask

    initial begin
        logic [7:0] q0 [$];
        logic [7:0] q1 [$];
        logic [8:0] d;
        logic [7:0] head;
        int exp_cc0, exp_cc1, bfe, bpe, w, lat, t0, perr_exp;
        bit badp;

        idle(3);
        check("rst_valid", 32'(rd_valid0), 32'd0);
        check("rst_data", 32'(rd_data0), 32'd0);
        check("rst_level", 32'(level0), 32'd0);
        check("rst_cnt", 32'(cc0), 32'd0);
        check("rst_ovf", 32'(ov0), 32'd0);
        check("rst_errs", 32'({fe0, pe0, fe1, pe1, fe2}), 32'd0);
        HRESETn = 1'b1;
        idle(4);

        send_ok(0, 9'h41, 8, 0, 1);
        w = 0;
        while (!rd_valid0 && w < 4) begin
            @(negedge HCLK);
            w++;
        end
        check("a41_valid", 32'(rd_valid0), 32'd1);
        check("a41_data", 32'(rd_data0), 32'h41);
        check("a41_cnt", 32'(cc0), 32'd1);
        pop(0);
        check("a41_popped", 32'(rd_valid0), 32'd0);
        exp_cc0 = 1;

        for (int k = 0; k < 10; k++) begin
            d = 9'($urandom_range(0, 255));
            send_ok(0, d, 8, 0, 1);
            q0.push_back(d[7:0]);
            exp_cc0++;
            idle($urandom_range(0, 24));
        end
        idle(2);
        check("rnd_level", 32'(level0), 32'(q0.size()));
        check("rnd_cnt", 32'(cc0), 32'(exp_cc0));
        while (q0.size() > 0) begin
            head = q0.pop_front();
            check("rnd_data", 32'(rd_data0), 32'(head));
            pop(0);
        end
        check("rnd_empty", 32'(rd_valid0), 32'd0);

        bfe = fe_n[0];
        bpe = pe_n[0];
        drive(0, 1'b0);
        idle(5);
        drive(0, 1'b1);
        idle(3 * CPB);
        check("glitch_level", 32'(level0), 32'd0);
        check("glitch_cnt", 32'(cc0), 32'(exp_cc0));
        check("glitch_pulses", 32'(fe_n[0] - bfe + pe_n[0] - bpe), 32'd0);
        send_ok(0, 9'h5A, 8, 0, 1);
        idle(2);
        exp_cc0++;
        check("after_glitch", 32'(rd_data0), 32'h5A);
        pop(0);

        bfe = fe_n[0];
        drive(0, 1'b0);
        idle(20 * CPB);
        drive(0, 1'b1);
        idle(2 * CPB);
        check("brk_ferr", 32'(fe_n[0] - bfe), 32'd1);
        check("brk_level", 32'(level0), 32'd0);
        check("brk_cnt", 32'(cc0), 32'(exp_cc0));
        send_ok(0, 9'h0D, 8, 0, 1);
        idle(2);
        check("brk_next", 32'(rd_data0), 32'h0D);
        pop(0);

        bfe = fe_n[1];
        bpe = pe_n[1];
        send(1, 9'h55, 8, 2, 1'b1, 2'b11, 1, 99);
        idle(4);
        check("par_perr", 32'(pe_n[1] - bpe), 32'd1);
        check("par_noferr", 32'(fe_n[1] - bfe), 32'd0);
        check("par_level", 32'(level1), 32'd0);
        send_ok(1, 9'h55, 8, 2, 1);
        idle(2);
        check("par_good", 32'(rd_data1), 32'h55);
        check("par_good_lvl", 32'(level1), 32'd1);
        pop(0 + 1);
        exp_cc1 = 1;

        perr_exp = pe_n[1];
        for (int k = 0; k < 6; k++) begin
            d = 9'($urandom_range(0, 255));
            badp = 1'($urandom_range(0, 1));
            send(1, d, 8, 2, badp, 2'b11, 1, 99);
            idle(2);
            perr_exp += int'(badp);
            check("rpar_perr", 32'(pe_n[1]), 32'(perr_exp));
            check("rpar_level", 32'(level1), badp ? 32'd0 : 32'd1);
            if (!badp) begin
                exp_cc1++;
                check("rpar_data", 32'(rd_data1), 32'(d[7:0]));
                pop(1);
            end
        end

        lat = 0;
        for (int k = 0; k < 5; k++) begin
            d = 9'($urandom_range(0, 255));
            send_ok(1, d, 8, 2, 1);
            if (k == 0) lat = cc1_chg - t_start;
            if (q1.size() < 4) begin
                q1.push_back(d[7:0]);
                exp_cc1++;
            end
            idle(3);
        end
        check("ovf_level", 32'(level1), 32'd4);
        check("ovf_set", 32'(ov1), 32'd1);
        check("ovf_cnt", 32'(cc1), 32'(exp_cc1));
        clr1 = 1'b1;
        @(negedge HCLK);
        clr1 = 1'b0;
        @(negedge HCLK);
        check("ovf_clr", 32'(ov1), 32'd0);

        if (lat < 2 || lat > 400) begin
            check("push_latency", 32'(lat), 32'd176);
        end else begin
            d = 9'($urandom_range(0, 255));
            t0 = pcyc;
            fork
                send_ok(1, d, 8, 2, 1);
                begin
                    while (pcyc < t0 + lat - 1) @(negedge HCLK);
                    rd_en1 = 1'b1;
                    @(negedge HCLK);
                    rd_en1 = 1'b0;
                end
            join
            void'(q1.pop_front());
            q1.push_back(d[7:0]);
            exp_cc1++;
            idle(3);
            check("both_level", 32'(level1), 32'd4);
            check("both_ovf", 32'(ov1), 32'd0);
            check("both_cnt", 32'(cc1), 32'(exp_cc1));
        end
        while (q1.size() > 0) begin
            head = q1.pop_front();
            check("full_order", 32'(rd_data1), 32'(head));
            pop(1);
        end

        bfe = fe_n[2];
        d = 9'($urandom_range(0, 127));
        send(2, d, 7, 0, 1'b0, 2'b01, 2, 99);
        idle(2 * CPB);
        check("stop2_ferr", 32'(fe_n[2] - bfe), 32'd1);
        check("stop2_level", 32'(level2), 32'd0);
        d = 9'($urandom_range(0, 127));
        send_ok(2, d, 7, 0, 2);
        idle(2);
        check("d7_data", 32'(rd_data2), 32'(d[6:0]));
        check("d7_cnt", 32'(cc2), 32'd1);

        send(2, 9'h2A, 7, 0, 1'b0, 2'b11, 2, 4);
        HRESETn = 1'b0;
        @(negedge HCLK);
        check("mid_rst_out",
              32'({rd_valid2, rd_data2, level2, fe2, pe2, ov2}), 32'd0);
        check("mid_rst_cnt", 32'(cc2), 32'd0);
        check("mid_rst_cnt0", 32'(cc0), 32'd0);
        HRESETn = 1'b1;
        idle(2 * CPB);
        d = 9'($urandom_range(0, 127));
        send_ok(2, d, 7, 0, 2);
        idle(2);
        check("post_rst_data", 32'(rd_data2), 32'(d[6:0]));
        check("post_rst_cnt", 32'(cc2), 32'd1);
        check("post_rst_lvl", 32'(level2), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
